uart_program_loader: RTL and testbench

- Upstream feeder for the 8-bit CPU's programming port.
- Receives a program image over an 8N1 serial line and buffers one full RAM image, RAM_BYTES bytes long.
- Streams the image into the CPU's programming handshake: drives programming and the ui_in byte, consumes ready_for_ui and done_load.
- Lets a host load CPU RAM with only one pin.

---
 rtl/uart_program_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Serial program loader: receives a sync-prefixed 8N1 image into a local buffer,
// then streams it byte by byte into the CPU programming handshake.
module uart_program_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          RAM_BYTES    = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       rx,
    input  logic       cpu_ready,
    input  logic       cpu_done,
    output logic       programming,
    output logic [7:0] prog_data,
    output logic       busy,
    output logic       loaded,
    output logic       frame_err,
    output logic       overrun
);

    localparam int PTR_W = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAM_BYTES - 1);

    // Handshake: the CPU consumes prog_data on every rising edge where
    // programming=1 and cpu_ready=1; cpu_done ends the load and wins over cpu_ready.

    logic rx_meta, rx_sync;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

    rx_state_t        rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       rx_bit, rx_bit_nx;
    logic [7:0]       rx_shift, rx_shift_nx;
    logic             rx_valid, rx_valid_nx;
    logic             rx_err, rx_err_nx;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_valid <= rx_valid_nx;
            rx_err   <= rx_err_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt + 1'b1;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_valid_nx = 1'b0;
        rx_err_nx   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nx = '0;
                if (!rx_sync) rx_state_nx = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_sync, rx_shift[7:1]};
                    rx_bit_nx   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx = '0;
                    if (rx_sync) begin
                        rx_valid_nx = 1'b1;
                        rx_state_nx = RX_IDLE;
                    end else begin
                        rx_err_nx   = 1'b1;
                        rx_state_nx = RX_HOLD;
                    end
                end
            end
            RX_HOLD: begin
                rx_cnt_nx = '0;
                if (rx_sync) rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    typedef enum logic [2:0] {WAIT_SYNC, COLLECT, STREAM, WAIT_DONE, DONE} state_t;

    state_t           state, state_nx;
    logic [PTR_W-1:0] wptr, wptr_nx, rptr, rptr_nx, rptr_inc;
    logic [7:0]       mem [RAM_BYTES];
    logic             buf_we;
    logic             programming_nx, busy_nx, loaded_nx, frame_err_nx, overrun_nx;
    logic [7:0]       prog_data_nx;

    assign rptr_inc = rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (buf_we) mem[wptr] <= rx_shift;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= WAIT_SYNC;
            wptr        <= '0;
            rptr        <= '0;
            programming <= 1'b0;
            prog_data   <= '0;
            busy        <= 1'b0;
            loaded      <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            wptr        <= wptr_nx;
            rptr        <= rptr_nx;
            programming <= programming_nx;
            prog_data   <= prog_data_nx;
            busy        <= busy_nx;
            loaded      <= loaded_nx;
            frame_err   <= frame_err_nx;
            overrun     <= overrun_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        wptr_nx        = wptr;
        rptr_nx        = rptr;
        programming_nx = programming;
        prog_data_nx   = prog_data;
        loaded_nx      = loaded;
        frame_err_nx   = frame_err | rx_err;
        overrun_nx     = overrun;
        buf_we         = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (rx_valid && rx_shift == SYNC_BYTE) begin
                    state_nx     = COLLECT;
                    wptr_nx      = '0;
                    frame_err_nx = 1'b0;
                    overrun_nx   = 1'b0;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    buf_we  = 1'b1;
                    wptr_nx = wptr + 1'b1;
                    if (wptr == PTR_LAST) begin
                        state_nx       = STREAM;
                        wptr_nx        = '0;
                        rptr_nx        = '0;
                        programming_nx = 1'b1;
                        prog_data_nx   = (wptr == '0) ? rx_shift : mem[0];
                    end
                end
            end
            STREAM: begin
                if (rx_valid) overrun_nx = 1'b1;
                if (cpu_done) begin
                    state_nx       = WAIT_SYNC;
                    programming_nx = 1'b0;
                    prog_data_nx   = '0;
                    loaded_nx      = 1'b0;
                end else if (cpu_ready) begin
                    if (rptr == PTR_LAST) begin
                        state_nx     = WAIT_DONE;
                        prog_data_nx = '0;
                    end else begin
                        rptr_nx      = rptr_inc;
                        prog_data_nx = mem[rptr_inc];
                    end
                end
            end
            WAIT_DONE: begin
                if (rx_valid) overrun_nx = 1'b1;
                prog_data_nx = '0;
                if (cpu_done) begin
                    state_nx       = DONE;
                    programming_nx = 1'b0;
                    loaded_nx      = 1'b1;
                end
            end
            DONE: begin
                if (rx_valid && rx_shift == SYNC_BYTE) begin
                    state_nx  = COLLECT;
                    wptr_nx   = '0;
                    loaded_nx = 1'b0;
                end
            end
            default: state_nx = WAIT_SYNC;
        endcase
        busy_nx = (state_nx == COLLECT) || (state_nx == STREAM) || (state_nx == WAIT_DONE);
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: random serial images checked against a
// byte-level model through an expected-byte queue.
`timescale 1ns/1ps
module tb_uart_program_loader;

    localparam int         CPB  = 16;
    localparam int         NB   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       clear, rx, cpu_ready, cpu_done;
    logic       programming, busy, loaded, frame_err, overrun;
    logic [7:0] prog_data;

    always #5 clk = ~clk;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .RAM_BYTES(NB), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .clear(clear), .rx(rx), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
        .programming(programming), .prog_data(prog_data), .busy(busy), .loaded(loaded),
        .frame_err(frame_err), .overrun(overrun)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    typedef enum {M_HUNT, M_FILL, M_BUSY, M_LOADED} mode_t;
    mode_t      m_mode;
    logic [7:0] m_img [NB];
    int         m_cnt;
    logic       m_loaded, m_frame_err, m_overrun;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the image byte at the queue front must be presented until consumed.
    always @(negedge clk) begin
        if (programming === 1'b1) begin
            if (exp_q.size() > 0) begin
                check("stream_byte", prog_data, exp_q[0]);
                if (cpu_ready && !cpu_done) void'(exp_q.pop_front());
            end else begin
                check("tail_zero", prog_data, 8'h00);
            end
        end else begin
            check("idle_zero", prog_data, 8'h00);
        end
    end

    task automatic model_reset();
        m_mode = M_HUNT; m_cnt = 0;
        m_loaded = 1'b0; m_frame_err = 1'b0; m_overrun = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_rx(input logic [7:0] b);
        case (m_mode)
            M_HUNT: if (b == SYNC) begin
                m_mode = M_FILL; m_cnt = 0; m_frame_err = 1'b0; m_overrun = 1'b0;
            end
            M_FILL: begin
                m_img[m_cnt] = b;
                m_cnt++;
                if (m_cnt == NB) begin
                    for (int i = 0; i < NB; i++) exp_q.push_back(m_img[i]);
                    m_mode = M_BUSY;
                end
            end
            M_BUSY: m_overrun = 1'b1;
            M_LOADED: if (b == SYNC) begin
                m_mode = M_FILL; m_cnt = 0; m_loaded = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic model_done_cmd();
        if (m_mode == M_BUSY) begin
            if (exp_q.size() == 0) begin
                m_mode = M_LOADED; m_loaded = 1'b1;
            end else begin
                m_mode = M_HUNT; m_loaded = 1'b0;
                exp_q.delete();
            end
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_busy"}, busy, (m_mode == M_FILL) || (m_mode == M_BUSY));
        check({tag, "_programming"}, programming, m_mode == M_BUSY);
        check({tag, "_loaded"}, loaded, m_loaded);
        check({tag, "_frame_err"}, frame_err, m_frame_err);
        check({tag, "_overrun"}, overrun, m_overrun);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_cycle(input logic r, input logic d);
        cpu_ready = r; cpu_done = d;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        repeat ($urandom_range(0, 3)) tick();
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_ok;
        repeat (CPB) tick();
        rx = 1'b1;
        if (!stop_ok) repeat (CPB) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_rx(b);
        send_frame(b, 1'b1);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_frame(b, 1'b0);
        m_frame_err = 1'b1;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
    endtask

    task automatic send_image(input int kind);
        send_byte(SYNC);
        check_flags("sync");
        for (int i = 0; i < NB; i++) begin
            if (kind == 0) send_byte(8'(i));
            else if (i == 5) send_byte(SYNC);
            else send_byte(8'($urandom_range(0, 255)));
        end
    endtask

    // mode 0: ready held high, 1: ready every 5th clock, 2: random ready
    task automatic run_stream(input int mode);
        int   guard;
        logic r;
        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (guard % 5 == 4);
                default: r = 1'($urandom_range(0, 1));
            endcase
            drive_cycle(r, 1'b0);
            guard++;
        end
        if (exp_q.size() > 0) begin
            vectors++; miscompares++;
            $display("FAIL stream_timeout: %0d bytes left, expected 0", exp_q.size());
            exp_q.delete();
        end
        if (mode != 0) cpu_ready = 1'b0;
    endtask

    task automatic consume_n(input int n);
        repeat (n) drive_cycle(1'b1, 1'b0);
        cpu_ready = 1'b0;
    endtask

    task automatic finish_load();
        drive_cycle(1'b0, 1'b1);
        cpu_done = 1'b0;
        model_done_cmd();
        check_flags("done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clear = 1'b1; rx = 1'b1; cpu_ready = 1'b0; cpu_done = 1'b0;
        model_reset();
        repeat (3) tick();
        check_flags("reset");
        check("reset_prog_data", prog_data, 8'h00);
        clear = 1'b0;
        tick();

        // Non-sync byte ignored, then counting image with ready held high.
        send_byte(8'h3C);
        check_flags("ignore_3c");
        cpu_ready = 1'b1;
        send_image(0);
        k = 0;
        while (programming !== 1'b1 && k < 2) begin tick(); k++; end
        check("prog_rise", programming, 1'b1);
        run_stream(0);
        repeat (3) tick();
        check("wait_done_prog", programming, 1'b1);
        check("wait_done_data", prog_data, 8'h00);
        check("wait_done_busy", busy, 1'b1);
        finish_load();

        // Reload from DONE; ready pulsed every 5th clock.
        send_image(0);
        run_stream(1);
        finish_load();

        // Short glitch on idle line, then overrun during streaming.
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
        check_flags("glitch");
        send_image(1);
        consume_n(3);
        send_byte(8'h5A);
        check_flags("overrun");
        run_stream(2);
        finish_load();

        // Early done after 4 bytes, with ready and done together.
        send_image(1);
        consume_n(4);
        drive_cycle(1'b1, 1'b1);
        cpu_done = 1'b0; cpu_ready = 1'b0;
        model_done_cmd();
        check_flags("abort");

        // Framing errors: in WAIT_SYNC, then inside an image (byte discarded).
        send_bad(8'h77);
        check_flags("ferr_hunt");
        send_byte(SYNC);
        check_flags("ferr_cleared");
        send_random(5);
        send_bad(8'hC3);
        check_flags("ferr_collect");
        send_random(NB - 5);
        run_stream(2);
        finish_load();

        // Asynchronous clear mid-stream, then a fresh image.
        send_image(1);
        consume_n(7);
        check("pre_clear_prog", programming, 1'b1);
        #2;
        clear = 1'b1;
        #1;
        check("clear_prog", programming, 1'b0);
        check("clear_data", prog_data, 8'h00);
        model_reset();
        tick();
        clear = 1'b0;
        tick();
        check_flags("after_clear");
        send_image(1);
        run_stream(2);
        finish_load();

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
